// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between
// the CPU memory stage and the SRAM controller. Read hits complete in the request cycle.
module cache_controller (
  input  logic        clock,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
);

  localparam int unsigned SETS   = 64;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned TAG_W  = 10;
  localparam int unsigned LINE_W = 64;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0] state, state_next;

  logic             word_sel;
  logic [IDX_W-1:0] set_idx;
  logic [TAG_W-1:0] tag;

  logic [SETS-1:0]   valid0, valid1, lru;
  logic [TAG_W-1:0]  tag0_mem  [SETS];
  logic [TAG_W-1:0]  tag1_mem  [SETS];
  logic [LINE_W-1:0] data0_mem [SETS];
  logic [LINE_W-1:0] data1_mem [SETS];

  logic              hit0, hit1, hit;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       hit_word, fill_word;
  logic              fill_en, write_upd, hit_touch;

  assign word_sel = address[2];
  assign set_idx  = address[8:3];
  assign tag      = address[18:9];

  // Lookup against the live address; valid bits gate both ways.
  assign hit0      = valid0[set_idx] && (tag0_mem[set_idx] == tag);
  assign hit1      = valid1[set_idx] && (tag1_mem[set_idx] == tag);
  assign hit       = hit0 || hit1;
  assign hit_line  = hit1 ? data1_mem[set_idx] : data0_mem[set_idx];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_read_data[63:32] : sram_read_data[31:0];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs; reset forces the idle output values immediately.
  always_comb begin
    state_next      = state;
    ready           = 1'b1;
    read_data       = 32'd0;
    sram_rd_en      = 1'b0;
    sram_wr_en      = 1'b0;
    sram_address    = 32'd0;
    sram_write_data = 32'd0;
    fill_en         = 1'b0;
    write_upd       = 1'b0;
    hit_touch       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            ready      = 1'b0;
            state_next = WRITE;
          end else if (rd_en) begin
            if (hit) begin
              read_data = hit_word;
              hit_touch = 1'b1;
            end else begin
              ready      = 1'b0;
              state_next = FILL;
            end
          end
        end
        FILL: begin
          sram_rd_en   = 1'b1;
          sram_address = {address[31:3], 3'b000};
          ready        = 1'b0;
          if (sram_ready) begin
            ready      = 1'b1;
            read_data  = fill_word;
            fill_en    = 1'b1;
            state_next = IDLE;
          end
        end
        WRITE: begin
          sram_wr_en      = 1'b1;
          sram_address    = address;
          sram_write_data = write_data;
          ready           = 1'b0;
          if (sram_ready) begin
            ready      = 1'b1;
            state_next = IDLE;
            write_upd  = hit;
            hit_touch  = hit;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Valid and LRU bits; LRU = 1 marks way 1 as the next victim.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (fill_en) begin
      if (lru[set_idx]) begin
        valid1[set_idx] <= 1'b1;
      end else begin
        valid0[set_idx] <= 1'b1;
      end
      lru[set_idx] <= ~lru[set_idx];
    end else if (hit_touch) begin
      lru[set_idx] <= hit0;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      if (lru[set_idx]) begin
        tag1_mem[set_idx]  <= tag;
        data1_mem[set_idx] <= sram_read_data;
      end else begin
        tag0_mem[set_idx]  <= tag;
        data0_mem[set_idx] <= sram_read_data;
      end
    end else if (write_upd) begin
      if (hit1) begin
        if (word_sel) data1_mem[set_idx][63:32] <= write_data;
        else          data1_mem[set_idx][31:0]  <= write_data;
      end else begin
        if (word_sel) data0_mem[set_idx][63:32] <= write_data;
        else          data0_mem[set_idx][31:0]  <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a recency-list cache model plus a flat
// word memory predict every response; a randomized-latency SRAM model answers requests.
module tb_cache_controller;

  logic        clock = 1'b0;
  logic        rst, rd_en, wr_en, ready, sram_rd_en, sram_wr_en, sram_ready;
  logic [31:0] address, write_data, read_data, sram_address, sram_write_data;
  logic [63:0] sram_read_data;

  always #5 clock = ~clock;

  cache_controller dut (
    .clock(clock), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Backing store seen by the SRAM model and the model's own view of memory.
  logic [31:0] sram_mem [int unsigned];
  logic [31:0] ref_mem  [int unsigned];

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] sram_get(logic [31:0] a);
    int unsigned k = 32'(a >> 2);
    if (sram_mem.exists(k)) return sram_mem[k];
    return init_word(a & ~32'h3);
  endfunction

  function automatic logic [31:0] ref_get(logic [31:0] a);
    int unsigned k = 32'(a >> 2);
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_word(a & ~32'h3);
  endfunction

  // Per-set recency list of at most two resident line tags.
  int          n_lines [64];
  logic [9:0]  mru_tag [64];
  logic [9:0]  lru_tag [64];

  function automatic void ref_reset();
    for (int s = 0; s < 64; s++) n_lines[s] = 0;
  endfunction

  function automatic bit ref_access(logic [31:0] a, bit alloc);
    int         s = int'(a[8:3]);
    logic [9:0] t = a[18:9];
    if (n_lines[s] >= 1 && mru_tag[s] == t) return 1'b1;
    if (n_lines[s] == 2 && lru_tag[s] == t) begin
      lru_tag[s] = mru_tag[s];
      mru_tag[s] = t;
      return 1'b1;
    end
    if (alloc) begin
      lru_tag[s] = mru_tag[s];
      mru_tag[s] = t;
      if (n_lines[s] < 2) n_lines[s]++;
    end
    return 1'b0;
  endfunction

  typedef struct {
    bit          is_wr;
    bit          hit;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  // SRAM model: responds to an enable after 0..3 extra cycles with a one-cycle pulse.
  int sram_cnt;
  bit sram_busy;
  int sram_force = -1;

  initial begin
    sram_ready     = 1'b0;
    sram_read_data = 64'd0;
    sram_busy      = 1'b0;
    sram_cnt       = 0;
    forever begin
      @(posedge clock);
      #2;
      sram_ready = 1'b0;
      if (rst) begin
        sram_busy = 1'b0;
      end else begin
        if (!sram_busy && (sram_rd_en || sram_wr_en)) begin
          sram_busy = 1'b1;
          sram_cnt  = (sram_force >= 0) ? sram_force : int'($urandom_range(0, 3));
        end
        if (sram_busy) begin
          if (sram_cnt == 0) begin
            sram_ready = 1'b1;
            sram_busy  = 1'b0;
            if (sram_wr_en) sram_mem[32'(sram_address >> 2)] = sram_write_data;
            else sram_read_data = {sram_get(sram_address | 32'h4), sram_get(sram_address & ~32'h4)};
          end else begin
            sram_cnt--;
          end
        end
      end
    end
  end

  // Monitor: checks SRAM-side traffic against the head of the queue and
  // pops one expectation whenever a CPU request completes.
  int   stall;
  bit   saw_rd, saw_wr;
  exp_t me;

  always @(negedge clock) begin
    if (rst) begin
      stall  = 0;
      saw_rd = 1'b0;
      saw_wr = 1'b0;
    end else begin
      if (sram_rd_en && sram_wr_en) chk("sram_exclusive", 64'd1, 64'd0);
      if (sram_rd_en || sram_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("sram_unexpected", 64'd1, 64'd0);
        end else begin
          me = exp_q[0];
          if (sram_rd_en) begin
            saw_rd = 1'b1;
            chk("fill_addr", 64'(sram_address), 64'({me.addr[31:3], 3'b000}));
          end
          if (sram_wr_en) begin
            saw_wr = 1'b1;
            chk("wt_addr", 64'(sram_address), 64'(me.addr));
            chk("wt_data", 64'(sram_write_data), 64'(me.data));
          end
        end
      end
      if (rd_en || wr_en) begin
        if (!ready) begin
          stall++;
        end else if (exp_q.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          me = exp_q.pop_front();
          if (me.is_wr) begin
            chk("wr_via_sram", 64'(saw_wr), 64'd1);
            chk("wr_no_fill", 64'(saw_rd), 64'd0);
            chk("wr_stalled", 64'(stall > 0), 64'd1);
          end else begin
            chk("rd_data", 64'(read_data), 64'(me.data));
            chk("rd_miss", 64'(saw_rd), 64'(!me.hit));
            chk("rd_stall", 64'(stall > 0), 64'(!me.hit));
          end
          stall  = 0;
          saw_rd = 1'b0;
          saw_wr = 1'b0;
        end
      end
    end
  end

  // Issue one request (called at posedge+1) and hold it until completion.
  task automatic issue(bit wr, bit both, logic [31:0] a, logic [31:0] d);
    exp_t e;
    bit   done;
    e.is_wr = wr;
    e.addr  = a;
    if (wr) begin
      e.hit = ref_access(a, 1'b0);
      e.data = d;
      ref_mem[32'(a >> 2)] = d;
    end else begin
      e.hit  = ref_access(a, 1'b1);
      e.data = ref_get(a);
    end
    exp_q.push_back(e);
    wr_en      = wr;
    rd_en      = !wr || both;
    address    = a;
    write_data = wr ? d : $urandom();
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clock);
      done = ready;
    end
    if (!done) chk("req_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_sram_rd_en"}, 64'(sram_rd_en), 64'd0);
    chk({tag, "_sram_wr_en"}, 64'(sram_wr_en), 64'd0);
    chk({tag, "_sram_address"}, 64'(sram_address), 64'd0);
    chk({tag, "_sram_write_data"}, 64'(sram_write_data), 64'd0);
    chk({tag, "_read_data"}, 64'(read_data), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    rst = 1'b1;
    exp_q.delete();
    ref_reset();
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int          g;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
    ref_reset();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;

    sram_mem[32'h10 >> 2] = 32'hAAAAAAAA; ref_mem[32'h10 >> 2] = 32'hAAAAAAAA;
    sram_mem[32'h14 >> 2] = 32'hBBBBBBBB; ref_mem[32'h14 >> 2] = 32'hBBBBBBBB;

    // First fill, same-line hit, write hit then read-back, write miss then read.
    issue(1'b0, 1'b0, 32'h10, 32'd0);
    issue(1'b0, 1'b0, 32'h14, 32'd0);
    issue(1'b1, 1'b0, 32'h14, 32'h12345678);
    issue(1'b0, 1'b0, 32'h14, 32'd0);
    issue(1'b1, 1'b0, 32'h818, 32'hCAFEF00D);
    issue(1'b0, 1'b0, 32'h818, 32'd0);

    // LRU replacement within index 2.
    do_reset();
    issue(1'b0, 1'b0, 32'h010, 32'd0);
    issue(1'b0, 1'b0, 32'h210, 32'd0);
    issue(1'b0, 1'b0, 32'h010, 32'd0);
    issue(1'b0, 1'b0, 32'h410, 32'd0);
    issue(1'b0, 1'b0, 32'h010, 32'd0);
    issue(1'b0, 1'b0, 32'h210, 32'd0);

    // Reset two cycles into a fill.
    do_reset();
    sram_force = 10;
    exp_q.push_back('{is_wr: 1'b0, hit: 1'b0, addr: 32'h10, data: 32'h0});
    rd_en = 1'b1; address = 32'h10;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_fill_reset");
    exp_q.delete();
    ref_reset();
    rd_en = 1'b0;
    sram_force = -1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    issue(1'b0, 1'b0, 32'h10, 32'd0);

    // Idle cycles, then simultaneous read/write enables.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_ready", 64'(ready), 64'd1);
      chk("idle_no_sram", 64'(sram_rd_en | sram_wr_en), 64'd0);
    end
    @(posedge clock);
    #1;
    issue(1'b1, 1'b1, 32'h10, 32'h0BADBEEF);
    issue(1'b0, 1'b0, 32'h10, 32'd0);

    // Random traffic over a few sets and tags to mix hits, misses and evictions.
    for (int n = 0; n < 300; n++) begin
      a = {13'd0, 8'd0, 2'($urandom_range(0, 3)), 4'd0, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 2'b00};
      if ($urandom_range(0, 99) < 35)
        issue(1'b1, $urandom_range(0, 9) == 0, a, $urandom());
      else
        issue(1'b0, 1'b0, a, 32'd0);
      g = int'($urandom_range(0, 2));
      repeat (g) @(posedge clock);
      if (g != 0) #1;
    end

    repeat (5) @(posedge clock);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
